// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase encoding and round-robin direction picker for traffic_ctrl_multi.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b000;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_OFF    = 3'b011;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } phase_t;

    // First direction after cur (wrapping, cur itself last) with demand; plain successor if none.
    function automatic logic [2:0] next_dir(input logic [2:0] cur, input logic [7:0] dem,
                                            input int num_dir);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'((int'(cur) + 1) % num_dir);
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= num_dir && !found) begin
                idx = (int'(cur) + k) % num_dir;
                if (dem[3'(idx)]) begin
                    pick  = 3'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by every dwell phase; it parks at zero until reloaded.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// N-direction intersection controller: one shared phase FSM, per-direction 3-bit lamps.
// Define TRAFFIC_FLASH_EN to add the flash_mode input and the flashing-yellow FLASH phase.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 20,
    parameter int MIN_GREEN  = 5,
    parameter int YELLOW_CYC = 4,
`ifdef TRAFFIC_FLASH_EN
    parameter int FLASH_CYC  = 8,
`endif
    parameter int ALLRED_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
`ifdef TRAFFIC_FLASH_EN
    input  logic                       flash_mode,
`endif
    input  logic [NUM_DIR-1:0]         demand,
    output logic [3*NUM_DIR-1:0]       light,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [1:0]                 phase
);

    localparam int DIR_W = $clog2(NUM_DIR);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GREEN_CYC - MIN_GREEN);
`ifdef TRAFFIC_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_CYC - 1);
`endif

    phase_t             state_q, state_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic [CNT_W-1:0]   cnt;
    logic               zero;
    logic [NUM_DIR-1:0] own_mask;
    logic               other_any;
`ifdef TRAFFIC_FLASH_EN
    logic               flash_on_q, flash_on_d;
`endif

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .dec      (en && !load),
        .cnt      (cnt),
        .zero     (zero)
    );

    assign own_mask  = NUM_DIR'(1) << dir_q;
    assign other_any = |(demand & ~own_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ALLRED;
            dir_q      <= DIR_W'(NUM_DIR - 1);
`ifdef TRAFFIC_FLASH_EN
            flash_on_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
`ifdef TRAFFIC_FLASH_EN
            flash_on_q <= flash_on_d;
`endif
        end
    end

    // With en low nothing loads or advances, so state, counter and direction all hold.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        load     = 1'b0;
        load_val = '0;
`ifdef TRAFFIC_FLASH_EN
        flash_on_d = flash_on_q;
`endif
        if (en) begin
`ifdef TRAFFIC_FLASH_EN
            if (flash_mode && state_q != FLASH) begin
                state_d    = FLASH;
                load       = 1'b1;
                load_val   = FLASH_LD;
                flash_on_d = 1'b1;
            end else begin
`else
            begin
`endif
                case (state_q)
                    ALLRED: begin
                        if (zero) begin
                            state_d  = GREEN;
                            dir_d    = DIR_W'(next_dir(3'(dir_q), 8'(demand), NUM_DIR));
                            load     = 1'b1;
                            load_val = GREEN_LD;
                        end
                    end
                    GREEN: begin
                        // Hold green past its dwell until someone else is actually waiting.
                        if (other_any && (zero || (cnt <= GAP_LIMIT && !demand[dir_q]))) begin
                            state_d  = YELLOW;
                            load     = 1'b1;
                            load_val = YELLOW_LD;
                        end
                    end
                    YELLOW: begin
                        if (zero) begin
                            state_d  = ALLRED;
                            load     = 1'b1;
                            load_val = ALLRED_LD;
                        end
                    end
`ifdef TRAFFIC_FLASH_EN
                    FLASH: begin
                        if (!flash_mode) begin
                            state_d  = ALLRED;
                            load     = 1'b1;
                            load_val = ALLRED_LD;
                        end else if (zero) begin
                            flash_on_d = !flash_on_q;
                            load       = 1'b1;
                            load_val   = FLASH_LD;
                        end
                    end
`endif
                    default: begin
                        state_d  = ALLRED;
                        load     = 1'b1;
                        load_val = ALLRED_LD;
                    end
                endcase
            end
        end
    end

    always_comb begin
        light = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (state_q == GREEN && dir_q == DIR_W'(i))
                light[3*i +: 3] = LAMP_GREEN;
            else if (state_q == YELLOW && dir_q == DIR_W'(i))
                light[3*i +: 3] = LAMP_YELLOW;
`ifdef TRAFFIC_FLASH_EN
            else if (state_q == FLASH)
                light[3*i +: 3] = flash_on_q ? LAMP_YELLOW : LAMP_OFF;
`endif
            else
                light[3*i +: 3] = LAMP_RED;
        end
    end

    assign active_dir = dir_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Table-driven scoreboard bench for traffic_ctrl_multi (2-direction and 4-direction instances).
// Flash-phase sequences are included when TRAFFIC_FLASH_EN is defined.
module tb_traffic_ctrl_multi;

    localparam logic [1:0] PH_ALLRED = 2'd0;
    localparam logic [1:0] PH_GREEN  = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;
    localparam logic [1:0] PH_FLASH  = 2'd3;

    typedef struct {
        logic       rst;
        logic       en;
        logic       fm;
        logic [3:0] demand;
        int         n;
        logic [1:0] ph;
        int         dir;
        logic       off;
    } vec_t;

    typedef struct {
        int          nd;
        logic [1:0]  ph;
        int          dir;
        logic [23:0] light;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fm = 1'b0;
    logic [1:0]  demand_a = '0;
    logic [3:0]  demand_b = '0;
    logic [5:0]  light_a;
    logic [11:0] light_b;
    logic        dir_a;
    logic [1:0]  dir_b;
    logic [1:0]  phase_a, phase_b;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk = ~clk;

    traffic_ctrl_multi dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef TRAFFIC_FLASH_EN
        .flash_mode (fm),
`endif
        .demand     (demand_a),
        .light      (light_a),
        .active_dir (dir_a),
        .phase      (phase_a)
    );

`ifdef TRAFFIC_FLASH_EN
    logic fm_b = 1'b0;
`endif

    traffic_ctrl_multi #(.NUM_DIR(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef TRAFFIC_FLASH_EN
        .flash_mode (fm_b),
`endif
        .demand     (demand_b),
        .light      (light_b),
        .active_dir (dir_b),
        .phase      (phase_b)
    );

    function automatic vec_t mk(input logic r, input logic e, input logic f, input logic [3:0] d,
                                input int n, input logic [1:0] ph, input int dir, input logic off);
        vec_t v;
        v.rst = r; v.en = e; v.fm = f; v.demand = d;
        v.n = n; v.ph = ph; v.dir = dir; v.off = off;
        return v;
    endfunction

    function automatic logic [23:0] exp_light(input int nd, input logic [1:0] ph, input int dir,
                                              input logic off);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            if (ph == PH_FLASH)
                r[3*i +: 3] = off ? 3'b011 : 3'b010;
            else if (i == dir && ph == PH_GREEN)
                r[3*i +: 3] = 3'b001;
            else if (i == dir && ph == PH_YELLOW)
                r[3*i +: 3] = 3'b010;
        end
        return r;
    endfunction

    // Each vector row holds its inputs for n cycles; expectations are queued as inputs are driven.
    task automatic apply_stimulus(input vec_t v, input int nd);
        exp_t e;
        repeat (v.n) begin
            @(posedge clk);
            #1;
            rst      = v.rst;
            en       = v.en;
            fm       = v.fm;
            demand_a = v.demand[1:0];
            demand_b = v.demand;
            e.nd     = nd;
            e.ph     = v.ph;
            e.dir    = v.dir;
            e.light  = exp_light(nd, v.ph, v.dir, v.off);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_output(input exp_t e);
        logic [1:0]  aph;
        int          adir;
        logic [23:0] alight;
        int          nonred;
        if (e.nd == 2) begin
            aph = phase_a; adir = int'(dir_a); alight = 24'(light_a);
        end else begin
            aph = phase_b; adir = int'(dir_b); alight = 24'(light_b);
        end
        vectors++;
        if (aph !== e.ph || adir != e.dir || alight !== e.light) begin
            miscompares++;
            $display("[TB] FAIL vec%0d (nd=%0d): got phase=%0d dir=%0d light=%h, want phase=%0d dir=%0d light=%h",
                     vectors, e.nd, aph, adir, alight, e.ph, e.dir, e.light);
        end
        nonred = 0;
        if (aph != PH_FLASH)
            for (int i = 0; i < e.nd; i++)
                if (alight[3*i +: 3] != 3'b000) nonred++;
        if (nonred > 1) begin
            miscompares++;
            $display("[TB] FAIL exclusive vec%0d: got %0d non-RED lamps, want at most 1", vectors, nonred);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0)
            check_output(exp_q.pop_front());
    end

    initial begin
        // Two-direction unit: nominal period, held green, gap exit, freeze, mid-green reset.
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_ALLRED, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11, 20, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  4, PH_YELLOW, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_ALLRED, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11, 20, PH_GREEN,  1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  4, PH_YELLOW, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_ALLRED, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b01,  1, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b01, 38, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  1, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b00,  4, PH_YELLOW, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b01,  2, PH_ALLRED, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b01,  1, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b10,  4, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b10,  4, PH_YELLOW, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b10,  2, PH_ALLRED, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11, 20, PH_GREEN,  1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_YELLOW, 1, 0));
        tab_a.push_back(mk(0, 0, 0, 4'b01, 10, PH_YELLOW, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_YELLOW, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_ALLRED, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  6, PH_GREEN,  0, 0));
        tab_a.push_back(mk(1, 1, 0, 4'b11,  1, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_ALLRED, 1, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  1, PH_GREEN,  0, 0));
`ifdef TRAFFIC_FLASH_EN
        tab_a.push_back(mk(0, 1, 1, 4'b11,  1, PH_GREEN,  0, 0));
        tab_a.push_back(mk(0, 1, 1, 4'b11,  8, PH_FLASH,  0, 0));
        tab_a.push_back(mk(0, 1, 1, 4'b11,  8, PH_FLASH,  0, 1));
        tab_a.push_back(mk(0, 1, 1, 4'b11,  7, PH_FLASH,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  1, PH_FLASH,  0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  2, PH_ALLRED, 0, 0));
        tab_a.push_back(mk(0, 1, 0, 4'b11,  1, PH_GREEN,  1, 0));
`endif
        // Four-direction unit with demand only on dirs 1 and 3.
        tab_b.push_back(mk(0, 1, 0, 4'b1010,  2, PH_ALLRED, 3, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010, 20, PH_GREEN,  1, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010,  4, PH_YELLOW, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010,  2, PH_ALLRED, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010, 20, PH_GREEN,  3, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010,  4, PH_YELLOW, 3, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010,  2, PH_ALLRED, 3, 0));
        tab_b.push_back(mk(0, 1, 0, 4'b1010,  1, PH_GREEN,  1, 0));

        rst = 1'b1;
        for (int i = 0; i < tab_a.size(); i++)
            apply_stimulus(tab_a[i], 2);

        @(posedge clk);
        #1;
        rst = 1'b1;
        fm  = 1'b0;
        for (int i = 0; i < tab_b.size(); i++)
            apply_stimulus(tab_b[i], 4);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
